hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core, companion to the EX-stage forwarding logic.
//  Resolves the hazards forwarding cannot: load-use bubbles, taken-branch IF flush and
//  multi-cycle data-memory waits with a timeout.
//  Drives all PC/pipeline-register write enables and flushes; keeps a stall-cycle count.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEM_WAIT cycles before fault (>=1)
//  CNT_W        16  width of stall-cycle counter
// PORTS
//  clk                  in   1      rising-edge clock
//  rst                  in   1      synchronous, active-high reset
//  ID_EX_mem_read_out   in   1      instruction in EX is a load
//  ID_EX_rt_out         in   5      load destination register in EX
//  IF_ID_rs_out         in   5      rs of instruction in ID
//  IF_ID_rt_out         in   5      rt of instruction in ID
//  branch_taken         in   1      ID-stage branch/jump resolved taken
//  EX_MEM_mem_access    in   1      instruction in MEM reads or writes data memory
//  mem_ready            in   1      data memory completes access this cycle
//  pc_write             out  1      PC load enable
//  IF_ID_write          out  1      IF/ID register load enable
//  IF_ID_flush          out  1      IF/ID register cleared to NOP
//  ID_EX_flush          out  1      bubble (zero control) inserted into ID/EX
//  pipe_hold            out  1      freeze ID/EX, EX/MEM, MEM/WB
//  mem_req              out  1      data-memory request strobe
//  mem_error            out  1      sticky timeout fault
//  stall_cycles         out  CNT_W  saturating count of cycles with pc_write=0
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, FAULT (2-bit register). rst -> RUN, wait_cnt=0,
//    stall_cycles=0, mem_error=0. Idle outputs: pc_write=1, IF_ID_write=1, all others 0.
//  - Outputs are combinational from state and current inputs. State and counters update on clk.
//  - mem_req = EX_MEM_mem_access in RUN and MEM_WAIT; 0 in FAULT.
//  - RUN, memory stall (EX_MEM_mem_access=1 && mem_ready=0):
//    pc_write=0, IF_ID_write=0, pipe_hold=1, no flushes; next MEM_WAIT, wait_cnt<=1.
//  - RUN, access with mem_ready=1 same cycle: no stall, stay RUN.
//  - RUN, load-use (no memory stall): ID_EX_mem_read_out && ID_EX_rt_out!=0 &&
//    (ID_EX_rt_out==IF_ID_rs_out || ID_EX_rt_out==IF_ID_rt_out).
//    pc_write=0, IF_ID_write=0, ID_EX_flush=1. Exactly one bubble; stay RUN.
//  - RUN, branch_taken, no stall: IF_ID_flush=1, PC advances normally.
//  - Priority: memory stall > load-use > branch.
//    branch_taken is ignored while stalled; the branch re-resolves after the stall.
//  - MEM_WAIT, mem_ready=0: full freeze as above; wait_cnt++.
//    If wait_cnt==MEM_TIMEOUT, next FAULT.
//  - MEM_WAIT, mem_ready=1: release this cycle; idle outputs, except that load-use and
//    branch are evaluated as in RUN. Next RUN, wait_cnt<=0.
//    mem_ready wins over timeout when both occur in the same cycle.
//  - FAULT: mem_error=1, full freeze, mem_req=0. Only rst exits this state.
//  - stall_cycles increments on every cycle with pc_write=0; it holds at 2^CNT_W-1.
//    It does not wrap.
//  - While rst=1, outputs are forced to idle values regardless of inputs.
//    Reset during MEM_WAIT or FAULT returns to RUN on the next edge.
// STRUCTURE
//  - hazard_pkg holds: state localparams (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2) and
//    REG_ZERO=5'd0. It is shared with the forwarding unit.
//  - Sub-module sat_counter #(W): en, rst, q; saturates at all-ones. Used for stall_cycles.
//  - FSM, wait counter and hazard compare live in this module.
// TESTING
//  - Load-use: lw writes $8 in EX, ID instruction rs=$8 -> one cycle with pc_write=0 and
//    ID_EX_flush=1, then resume; stall_cycles=1.
//  - rt=0 load: ID_EX_rt_out=0, IF_ID_rs_out=0, mem_read=1 -> no stall.
//  - Branch: branch_taken=1, no hazard -> IF_ID_flush=1 for 1 cycle, pc_write=1.
//    With a simultaneous load-use -> stall only, IF_ID_flush=0.
//  - Memory wait: access with mem_ready low 3 cycles, then high -> pipe_hold=1 for 3 cycles,
//    release on the 4th cycle, mem_req high all 4 cycles; stall_cycles=3.
//  - Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> FAULT after 4 MEM_WAIT cycles,
//    mem_error=1 and stays set; rst -> RUN and mem_error=0.
//    Also cover mem_ready=1 in the cycle wait_cnt==4 -> RUN, no fault.
//  - Saturation: CNT_W=3, hold a memory stall for 10 cycles -> stall_cycles stops at 7.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared hazard definitions: pipeline sequencer states and register constants.
// Also imported by the EX-stage forwarding unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt
  );
    return mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard sequencer bundle: pipeline status in, stall/flush controls out.
// master drives pipeline status; slave is the sequencer.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             ID_EX_mem_read_out;
  logic [4:0]       ID_EX_rt_out;
  logic [4:0]       IF_ID_rs_out;
  logic [4:0]       IF_ID_rt_out;
  logic             branch_taken;
  logic             EX_MEM_mem_access;
  logic             mem_ready;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_hold;
  logic             mem_req;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ID_EX_mem_read_out, ID_EX_rt_out,
    output IF_ID_rs_out, IF_ID_rt_out,
    output branch_taken, EX_MEM_mem_access,
    output mem_ready,
    input  pc_write, IF_ID_write, IF_ID_flush,
    input  ID_EX_flush, pipe_hold, mem_req,
    input  mem_error, stall_cycles
  );

  modport slave (
    input  ID_EX_mem_read_out, ID_EX_rt_out,
    input  IF_ID_rs_out, IF_ID_rt_out,
    input  branch_taken, EX_MEM_mem_access,
    input  mem_ready,
    output pc_write, IF_ID_write, IF_ID_flush,
    output ID_EX_flush, pipe_hold, mem_req,
    output mem_error, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, taken-branch IF flush and
// data-memory wait with timeout fault; counts cycles with the PC frozen.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_stall_controller_if.slave bus
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 2 :
                      $clog2(MEM_TIMEOUT + 2);
  localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;

  logic pc_write, if_id_write, if_id_flush;
  logic id_ex_flush, pipe_hold, mem_req, mem_error;
  logic mem_stall, load_use;
  logic [CNT_W-1:0] stall_q;

  assign mem_stall = bus.EX_MEM_mem_access & ~bus.mem_ready;
  assign load_use  = load_use_hit(bus.ID_EX_mem_read_out,
                                  bus.ID_EX_rt_out,
                                  bus.IF_ID_rs_out,
                                  bus.IF_ID_rt_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_req     = 1'b0;
    mem_error   = 1'b0;
    state_nx    = state;
    wait_nx     = wait_cnt;
    if (!rst) begin
      unique case (state)
        RUN: begin
          mem_req = bus.EX_MEM_mem_access;
          if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            state_nx    = MEM_WAIT;
            wait_nx     = WW'(1);
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (bus.branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req = bus.EX_MEM_mem_access;
          if (bus.mem_ready) begin
            // release cycle behaves like a normal RUN cycle
            state_nx = RUN;
            wait_nx  = '0;
            if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end else if (bus.branch_taken) begin
              if_id_flush = 1'b1;
            end
          end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            wait_nx     = wait_cnt + 1'b1;
            if (wait_cnt == TO)
              state_nx = FAULT;
          end
        end
        FAULT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          mem_error   = 1'b1;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (~pc_write),
    .q   (stall_q)
  );

  assign bus.pc_write     = pc_write;
  assign bus.IF_ID_write  = if_id_write;
  assign bus.IF_ID_flush  = if_id_flush;
  assign bus.ID_EX_flush  = id_ex_flush;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.mem_req      = mem_req;
  assign bus.mem_error    = mem_error;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller.
// Directed per-cycle vectors; a monitor checks them at the falling edge.
module tb_hazard_stall_controller;

  localparam int CW = 3;

  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
  //  pipe_hold, mem_req, mem_error}
  localparam logic [6:0] IDLE  = 7'b1100000;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1110000;
  localparam logic [6:0] FRZ   = 7'b0000110;
  localparam logic [6:0] ACC   = 7'b1100010;
  localparam logic [6:0] FLT   = 7'b0000101;
  localparam logic [6:0] RELBR = 7'b1110010;
  localparam logic [6:0] RELLU = 7'b0001010;

  typedef struct {
    string          name;
    logic [6:0]     e;
    logic [CW-1:0]  c;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   applied;
  int   miscompares;

  hazard_stall_controller_if #(.CNT_W(CW)) bus ();

  hazard_stall_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic s(
    input string      nm,
    input logic       r,
    input logic       mr,
    input logic [4:0] ert,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       br,
    input logic       acc,
    input logic       rdy,
    input logic [6:0] e,
    input int         c
  );
    exp_t x;
    @(posedge clk);
    #1;
    rst                    = r;
    bus.ID_EX_mem_read_out = mr;
    bus.ID_EX_rt_out       = ert;
    bus.IF_ID_rs_out       = rs;
    bus.IF_ID_rt_out       = rt;
    bus.branch_taken       = br;
    bus.EX_MEM_mem_access  = acc;
    bus.mem_ready          = rdy;
    x.name = nm;
    x.e    = e;
    x.c    = CW'(c);
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [6:0] got;
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      got = {bus.pc_write, bus.IF_ID_write,
             bus.IF_ID_flush, bus.ID_EX_flush,
             bus.pipe_hold, bus.mem_req,
             bus.mem_error};
      applied++;
      if (got !== x.e || bus.stall_cycles !== x.c) begin
        miscompares++;
        $display("FAIL %s: got out=%b cnt=%0d, want out=%b cnt=%0d",
                 x.name, got, bus.stall_cycles, x.e, x.c);
      end
    end
  end

  initial begin
    applied                = 0;
    miscompares            = 0;
    rst                    = 1'b1;
    bus.ID_EX_mem_read_out = 1'b0;
    bus.ID_EX_rt_out       = 5'd0;
    bus.IF_ID_rs_out       = 5'd0;
    bus.IF_ID_rt_out       = 5'd0;
    bus.branch_taken       = 1'b0;
    bus.EX_MEM_mem_access  = 1'b0;
    bus.mem_ready          = 1'b0;

    s("rst0",       1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    s("rst_force",  1, 1, 8, 8, 0, 1, 1, 0, IDLE, 0);
    // load-use on rs, then on rt
    s("lu_rs",      0, 1, 8, 8, 0, 0, 0, 0, LU,   0);
    s("lu_bubble",  0, 0, 0, 8, 0, 0, 0, 0, IDLE, 1);
    s("lu_rt",      0, 1, 9, 3, 9, 0, 0, 0, LU,   1);
    s("lu_rt_post", 0, 0, 0, 3, 9, 0, 0, 0, IDLE, 2);
    s("r0_load",    0, 1, 0, 0, 0, 0, 0, 0, IDLE, 2);
    s("no_load",    0, 0, 4, 4, 4, 0, 0, 0, IDLE, 2);
    // branch alone, then branch with load-use
    s("br",         0, 0, 0, 0, 0, 1, 0, 0, BR,   2);
    s("br_post",    0, 0, 0, 0, 0, 0, 0, 0, IDLE, 2);
    s("br_lu",      0, 1, 5, 5, 0, 1, 0, 0, LU,   2);
    s("br_resolve", 0, 0, 0, 5, 0, 1, 0, 0, BR,   3);
    s("acc_rdy",    0, 0, 0, 0, 0, 0, 1, 1, ACC,  3);
    s("rst_a",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 3);
    s("rst_b",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    // three wait cycles then release
    s("mw1_lu",     0, 1, 6, 6, 0, 0, 1, 0, FRZ,  0);
    s("mw2_br",     0, 0, 0, 0, 0, 1, 1, 0, FRZ,  1);
    s("mw3",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2);
    s("mw_rel",     0, 0, 0, 0, 0, 0, 1, 1, ACC,  3);
    s("mw_idle",    0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3);
    s("mwb1",       0, 0, 0, 0, 0, 0, 1, 0, FRZ,  3);
    s("rel_br",     0, 0, 0, 0, 0, 1, 1, 1, RELBR, 4);
    s("rel_br_idl", 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 4);
    s("mwc1",       0, 0, 0, 0, 0, 0, 1, 0, FRZ,  4);
    s("rel_lu",     0, 1, 7, 7, 0, 0, 1, 1, RELLU, 5);
    s("rel_lu_idl", 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 6);
    s("rst_c",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 6);
    s("rst_d",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    // timeout into FAULT, sticky until reset
    s("to1",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0);
    s("to2",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1);
    s("to3",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2);
    s("to4",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  3);
    s("to5",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  4);
    s("fault",      0, 0, 0, 0, 0, 0, 1, 0, FLT,  5);
    s("fault_rdy",  0, 1, 8, 8, 0, 1, 1, 1, FLT,  6);
    s("fault_sat",  0, 0, 0, 0, 0, 0, 0, 0, FLT,  7);
    s("fault_sat2", 0, 0, 0, 0, 0, 0, 1, 0, FLT,  7);
    s("rst_fault",  1, 0, 0, 0, 0, 0, 1, 0, IDLE, 7);
    s("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    // ready arrives exactly when wait_cnt hits the limit
    s("tr1",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0);
    s("tr2",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1);
    s("tr3",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2);
    s("tr4",        0, 0, 0, 0, 0, 0, 1, 0, FRZ,  3);
    s("tr_rel",     0, 0, 0, 0, 0, 0, 1, 1, ACC,  4);
    s("tr_idle",    0, 0, 0, 0, 0, 0, 0, 0, IDLE, 4);
    s("rst_e",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 4);
    s("rst_f",      1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    // 10 stalled cycles with a 3-bit counter
    for (int i = 0; i < 10; i++)
      s("sat", 0, 0, 0, 0, 0, 0, 1, 0,
        (i < 5) ? FRZ : FLT, (i < 7) ? i : 7);

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
